// File: rtl/apb_reg_ctrl.sv
// APB slave front-end for a word-addressed register bank: decodes captured setup fields,
// inserts WAIT_CYCLES wait states, flags errors and emits one-hot write pulses / read mux.
module apb_reg_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int NREG = 8,
  parameter logic [NREG-1:0] RO_MASK = 8'b1000_0000,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W/8-1:0]      pstrb,
  output logic                     pready,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pslverr,
  output logic [NREG-1:0]          reg_wen,
  output logic [DATA_W-1:0]        reg_wdata,
  output logic [DATA_W/8-1:0]      reg_wstrb,
  input  logic [NREG*DATA_W-1:0]   reg_rdata
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_write;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W/8-1:0] cap_strb;

  logic [IDX_W-1:0]    idx;
  logic [NREG-1:0]     sel;
  logic [DATA_W-1:0]   rsel;
  logic                err;
  logic                done;

  assign idx = cap_addr[ADDR_W-1:2];

  // One-hot decode; an out-of-range index leaves sel all-zero.
  always_comb begin
    sel  = '0;
    rsel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (32'(idx) == i) begin
        sel[i] = 1'b1;
        rsel   = reg_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign err  = (cap_addr[1:0] != 2'b00) || (sel == '0) || (cap_write && ((sel & RO_MASK) != '0));
  assign done = (state == ACCESS) && psel && penable && (cnt == WAIT_C);

  assign pready    = done;
  assign pslverr   = done && err;
  assign reg_wen   = (done && cap_write && !err) ? sel : '0;
  assign reg_wdata = cap_wdata;
  assign reg_wstrb = cap_strb;
  assign prdata    = (done && !cap_write && !err) ? rsel : '0;

  // A back-to-back setup after pready is seen in IDLE and re-enters ACCESS on the
  // same edge a fresh transfer would, so the two pready pulses land 2 cycles apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state     <= ACCESS;
            cnt       <= '0;
            cap_addr  <= paddr;
            cap_write <= pwrite;
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
          end
        end
        ACCESS: begin
          if (done || !psel) begin
            state <= IDLE;
          end else if (cnt < WAIT_C) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_ctrl.sv
// Bench: three DUTs (0, 2, 3 wait states) each backed by a byte-strobed register bank model.
module tb_apb_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready [3];
  logic        pslverr [3];
  logic [31:0] prdata [3];
  logic [7:0]  reg_wen [3];
  logic [31:0] reg_wdata [3];
  logic [3:0]  reg_wstrb [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < 3; g++) begin : gen_dut
    logic [31:0]  bank [8];
    logic [255:0] rdata_flat;

    apb_reg_ctrl #(
      .ADDR_W(12), .DATA_W(32), .NREG(8), .RO_MASK(8'b1000_0000),
      .WAIT_CYCLES(g == 0 ? 0 : g + 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .psel(psel[g]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[g]),
      .prdata(prdata[g]), .pslverr(pslverr[g]), .reg_wen(reg_wen[g]),
      .reg_wdata(reg_wdata[g]), .reg_wstrb(reg_wstrb[g]), .reg_rdata(rdata_flat)
    );

    always_comb begin
      rdata_flat = '0;
      for (int i = 0; i < 8; i++) rdata_flat[i*32 +: 32] = bank[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) bank[i] <= 32'h1111_0000 | 32'(i);
      end else begin
        for (int i = 0; i < 8; i++)
          if (reg_wen[g][i])
            for (int b = 0; b < 4; b++)
              if (reg_wstrb[g][b]) bank[i][b*8 +: 8] <= reg_wdata[g][b*8 +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transfer on DUT k; waits = penable cycles before pready (20 = timeout).
  task automatic xfer(input int k, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int waits, output logic err,
                      output logic [31:0] rd, output logic [7:0] wen, output logic [31:0] wd,
                      output logic [3:0] ws, output logic stray);
    logic fin;
    waits = 0; err = 0; rd = 0; wen = 0; wd = 0; ws = 0; stray = 0; fin = 0;
    @(posedge clk); #1;
    psel[k] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    if (pready[k] || reg_wen[k] != 8'h0) stray = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (pready[k]) begin
        fin = 1'b1; err = pslverr[k]; rd = prdata[k]; wen = reg_wen[k];
        wd = reg_wdata[k]; ws = reg_wstrb[k];
      end else begin
        if (reg_wen[k] != 8'h0) stray = 1'b1;
        waits++;
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          ew;
    logic        ee;
    logic [31:0] er;
    logic [7:0]  en;
  } vec_t;

  vec_t vt [14];

  initial begin
    int waits;
    logic err, stray;
    logic [31:0] rd, wd;
    logic [7:0] wen;
    logic [3:0] ws;

    vt[0]  = '{0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0,        8'h02};
    vt[1]  = '{0, 1'b0, 12'h004, 32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF, 8'h00};
    vt[2]  = '{0, 1'b1, 12'h01C, 32'h12345678, 4'hF, 0, 1'b1, 32'h0,        8'h00};
    vt[3]  = '{0, 1'b0, 12'h01C, 32'h0,        4'h0, 0, 1'b0, 32'h11110007, 8'h00};
    vt[4]  = '{0, 1'b0, 12'h020, 32'h0,        4'h0, 0, 1'b1, 32'h0,        8'h00};
    vt[5]  = '{0, 1'b1, 12'h006, 32'h55555555, 4'hF, 0, 1'b1, 32'h0,        8'h00};
    vt[6]  = '{0, 1'b1, 12'h00C, 32'hCAFEF00D, 4'h5, 0, 1'b0, 32'h0,        8'h08};
    vt[7]  = '{0, 1'b0, 12'h00C, 32'h0,        4'h0, 0, 1'b0, 32'h11FE000D, 8'h00};
    vt[8]  = '{0, 1'b1, 12'h010, 32'hAAAA5555, 4'h0, 0, 1'b0, 32'h0,        8'h10};
    vt[9]  = '{0, 1'b0, 12'h010, 32'h0,        4'h0, 0, 1'b0, 32'h11110004, 8'h00};
    vt[10] = '{0, 1'b0, 12'h003, 32'h0,        4'h0, 0, 1'b1, 32'h0,        8'h00};
    vt[11] = '{2, 1'b1, 12'h008, 32'h00001234, 4'hF, 3, 1'b0, 32'h0,        8'h04};
    vt[12] = '{2, 1'b0, 12'h008, 32'h0,        4'h0, 3, 1'b0, 32'h00001234, 8'h00};
    vt[13] = '{1, 1'b0, 12'h000, 32'h0,        4'h0, 2, 1'b0, 32'h11110000, 8'h00};

    rst_n = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pready%0d", k), 32'(pready[k]), 32'h0);
      chk($sformatf("rst_pslverr%0d", k), 32'(pslverr[k]), 32'h0);
      chk($sformatf("rst_prdata%0d", k), prdata[k], 32'h0);
      chk($sformatf("rst_wen%0d", k), 32'(reg_wen[k]), 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      xfer(vt[i].k, vt[i].w, vt[i].a, vt[i].d, vt[i].s, waits, err, rd, wen, wd, ws, stray);
      chk($sformatf("v%0d_waits", i), 32'(waits), 32'(vt[i].ew));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].ee));
      chk($sformatf("v%0d_prdata", i), rd, vt[i].er);
      chk($sformatf("v%0d_wen", i), 32'(wen), 32'(vt[i].en));
      chk($sformatf("v%0d_stray", i), 32'(stray), 32'h0);
      if (vt[i].en != 8'h0) begin
        chk($sformatf("v%0d_wdata", i), wd, vt[i].d);
        chk($sformatf("v%0d_wstrb", i), 32'(ws), 32'(vt[i].s));
      end
    end

    // Back-to-back write then read of register 0 with no idle cycle.
    @(posedge clk); #1;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h600DF00D; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("b2b_rdy1", 32'(pready[0]), 32'h1);
    chk("b2b_wen", 32'(reg_wen[0]), 32'h01);
    @(posedge clk); #1; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    chk("b2b_gap", 32'(pready[0]), 32'h0);
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("b2b_rdy2", 32'(pready[0]), 32'h1);
    chk("b2b_prdata", prdata[0], 32'h600DF00D);
    chk("b2b_rd_wen", 32'(reg_wen[0]), 32'h0);
    @(posedge clk); #1; psel[0] = 1'b0; penable = 1'b0;

    // Abort: psel dropped during the wait states of DUT with 2 waits.
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h0BADBAD0; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("abort_wait", {pready[1], reg_wen[1]}, 32'h0);
    @(posedge clk); #1; psel[1] = 1'b0; penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("abort_idle%0d", c), {pready[1], reg_wen[1]}, 32'h0);
    end
    xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, waits, err, rd, wen, wd, ws, stray);
    chk("abort_next_waits", 32'(waits), 32'd2);
    chk("abort_next_prdata", rd, 32'h11110000);

    // Reset asserted in a wait state of DUT with 3 waits, bus held active through release.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h00000099; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    chk("rstw_wait", 32'(pready[2]), 32'h0);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_pready", 32'(pready[2]), 32'h0);
    chk("rstw_pslverr", 32'(pslverr[2]), 32'h0);
    chk("rstw_prdata", prdata[2], 32'h0);
    chk("rstw_wen", 32'(reg_wen[2]), 32'h0);
    chk("rstw_wdata", reg_wdata[2], 32'h0);
    chk("rstw_wstrb", 32'(reg_wstrb[2]), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rstw_post%0d", c), {pready[2], reg_wen[2]}, 32'h0);
    end
    @(posedge clk); #1; psel[2] = 1'b0; penable = 1'b0;
    xfer(2, 1'b0, 12'h004, 32'h0, 4'h0, waits, err, rd, wen, wd, ws, stray);
    chk("rstw_next_waits", 32'(waits), 32'd3);
    chk("rstw_next_prdata", rd, 32'h11110001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
